// File: rtl/dout_pkg.sv
// Shared register map, bus response code and FSM state types for the dout AXI4-Lite register block.
// Also holds the byte-strobe merge used on every register write.
package dout_pkg;

  localparam logic [3:0] OFS_DOUT      = 4'h0;
  localparam logic [3:0] OFS_OE        = 4'h4;
  localparam logic [3:0] OFS_PULSE_LEN = 4'h8;
  localparam logic [3:0] OFS_CTRL      = 4'hC;

  localparam logic [1:0] REG_DOUT      = OFS_DOUT[3:2];
  localparam logic [1:0] REG_OE        = OFS_OE[3:2];
  localparam logic [1:0] REG_PULSE_LEN = OFS_PULSE_LEN[3:2];
  localparam logic [1:0] REG_CTRL      = OFS_CTRL[3:2];

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_AW,
    W_WAIT_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dout_axil_regs_if.sv
// AXI4-Lite bus bundle (32-bit data) between a master and dout_axil_regs.
// Pure wiring, no latency; flow control is the usual per-channel VALID/READY.
interface dout_axil_regs_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/dout_pulse_timer.sv
// Pulse-mode down-counter (DOUT_PULSE_EN builds only): load restarts at len, expired goes high len cycles later.
// len=0 never expires; expired is sticky until the next load. No backpressure.
module dout_pulse_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] len,
  output logic        expired
);
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt     <= len;
      expired <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 32'd1;
      if (cnt == 32'd1) expired <= 1'b1;
    end
  end
endmodule

// File: rtl/dout_axil_regs.sv
// AXI4-Lite DOUT/OE/PULSE_LEN/CTRL registers driving dout (DOUT & OE) one cycle after a write commit; DOUT_PULSE_EN adds pulse mode.
// BVALID one cycle after the last write beat, RVALID one cycle after AR; one write and one read outstanding, held until BREADY/RREADY.
module dout_axil_regs
  import dout_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int N_OUT              = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  dout_axil_regs_if.slave  s_axi,
  output logic [N_OUT-1:0] dout
);
  w_state_t                      w_state;
  r_state_t                      r_state;
  logic                          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, c_addr;
  logic [31:0]                   w_data_q, c_data;
  logic [3:0]                    w_strb_q, c_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic                          aw_hs, w_hs, aw_have, w_have, commit;
  logic [1:0]                    c_idx;
  logic                          pulse_gate;
  logic                          unused_bits;

  assign aw_hs   = s_axi.AWVALID && awready_q;
  assign w_hs    = s_axi.WVALID && wready_q;
  assign aw_have = (w_state == W_WAIT_DATA) || aw_hs;
  assign w_have  = (w_state == W_WAIT_AW) || w_hs;
  assign commit  = (w_state != W_RESP) && aw_have && w_have;

  // Each beat comes from its holding register if it arrived earlier, else straight off the bus.
  assign c_addr = (w_state == W_WAIT_DATA) ? aw_addr_q : s_axi.AWADDR;
  assign c_data = (w_state == W_WAIT_AW) ? w_data_q : s_axi.WDATA;
  assign c_strb = (w_state == W_WAIT_AW) ? w_strb_q : s_axi.WSTRB;
  assign c_idx  = c_addr[3:2];

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = RESP_OKAY;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = RESP_OKAY;

  assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, c_addr[1:0], s_axi.ARADDR[1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      awready_q <= s_axi.AWVALID && !awready_q && (w_state == W_IDLE || w_state == W_WAIT_AW);
      wready_q  <= s_axi.WVALID && !wready_q && (w_state == W_IDLE || w_state == W_WAIT_DATA);
      if (commit) begin
        w_state  <= W_RESP;
        bvalid_q <= 1'b1;
      end else begin
        case (w_state)
          W_IDLE: begin
            if (aw_hs) begin
              aw_addr_q <= s_axi.AWADDR;
              w_state   <= W_WAIT_DATA;
            end else if (w_hs) begin
              w_data_q <= s_axi.WDATA;
              w_strb_q <= s_axi.WSTRB;
              w_state  <= W_WAIT_AW;
            end
          end
          W_RESP: begin
            if (s_axi.BREADY) begin
              bvalid_q <= 1'b0;
              w_state  <= W_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= s_axi.ARVALID && !arready_q;
          if (s_axi.ARVALID && arready_q) begin
            // Sampled before any same-edge write commit lands, so reads see the old value.
            rdata_q  <= regs[s_axi.ARADDR[3:2]];
            rvalid_q <= 1'b1;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          arready_q <= 1'b0;
          if (s_axi.RREADY) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[c_idx] <= apply_wstrb(regs[c_idx], c_data, c_strb);
    end
  end

`ifdef DOUT_PULSE_EN
  logic pulse_expired;

  dout_pulse_timer u_pulse_timer (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .load    (commit && (c_idx == REG_DOUT)),
    .len     (regs[REG_PULSE_LEN]),
    .expired (pulse_expired)
  );

  assign pulse_gate = regs[REG_CTRL][0] && pulse_expired;
`else
  assign pulse_gate = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dout <= '0;
    end else begin
      dout <= pulse_gate ? '0 : (regs[REG_DOUT][N_OUT-1:0] & regs[REG_OE][N_OUT-1:0]);
    end
  end
endmodule

// File: tb/tb_dout_axil_regs.sv
// Bench for dout_axil_regs: directed cases plus randomized writes/reads checked against an array model of the register file.
module tb_dout_axil_regs;
  import dout_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [15:0] dout;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mregs [4];

  dout_axil_regs_if #(.ADDR_W(4)) axi ();

  dout_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .N_OUT(16)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_axi   (axi),
    .dout    (dout)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic [15:0] exp_dout();
    return mregs[0][15:0] & mregs[1][15:0];
  endfunction

  // mode 0: AW and W together, 1: AW leads W by gap cycles, 2: W leads AW by gap cycles
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int mode, input int gap, input int bdly);
    logic        aw_done, w_done, aw_fire, w_fire, early;
    logic [15:0] old_dout;
    int          t;
    aw_done = 0; w_done = 0; early = 0; t = 0;
    old_dout = exp_dout();
    axi.AWADDR  = addr;
    axi.WDATA   = data;
    axi.WSTRB   = strb;
    axi.AWVALID = (mode != 2);
    axi.WVALID  = (mode != 1);
    while (!(aw_done && w_done) && t < 40) begin
      if (mode == 1 && t == gap) axi.WVALID = 1;
      if (mode == 2 && t == gap) axi.AWVALID = 1;
      aw_fire = axi.AWVALID && axi.AWREADY;
      w_fire  = axi.WVALID && axi.WREADY;
      @(posedge ACLK); #1; t++;
      if (aw_fire) begin axi.AWVALID = 0; aw_done = 1; end
      if (w_fire)  begin axi.WVALID = 0;  w_done = 1;  end
      if (!(aw_done && w_done)) early |= axi.BVALID;
    end
    if (!(aw_done && w_done)) begin
      chk("wr_handshake_timeout", 32'd0, 32'd1);
      axi.AWVALID = 0;
      axi.WVALID  = 0;
      return;
    end
    mregs[addr[3:2]] = merge(mregs[addr[3:2]], data, strb);
    chk("bvalid_early", early, 0);
    chk("bvalid_rise", axi.BVALID, 1);
    chk("bresp", axi.BRESP, RESP_OKAY);
    chk("dout_pre", dout, old_dout);
    for (int i = 0; i < bdly; i++) begin
      @(posedge ACLK); #1;
      if (i == 0) chk("dout_post", dout, exp_dout());
      chk("bvalid_hold", axi.BVALID, 1);
    end
    axi.BREADY = 1;
    @(posedge ACLK); #1;
    axi.BREADY = 0;
    if (bdly == 0) chk("dout_post", dout, exp_dout());
    chk("bvalid_clear", axi.BVALID, 0);
  endtask

  task automatic axi_read_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic fire, done;
    int   t, hold;
    done = 0; t = 0;
    axi.ARADDR  = addr;
    axi.ARVALID = 1;
    while (!done && t < 20) begin
      fire = axi.ARVALID && axi.ARREADY;
      @(posedge ACLK); #1; t++;
      if (fire) begin axi.ARVALID = 0; done = 1; end
    end
    if (!done) begin
      chk({tag, "_ar_timeout"}, 32'd0, 32'd1);
      axi.ARVALID = 0;
      return;
    end
    chk({tag, "_rvalid"}, axi.RVALID, 1);
    chk(tag, axi.RDATA, exp);
    chk({tag, "_rresp"}, axi.RRESP, RESP_OKAY);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      chk({tag, "_hold"}, axi.RDATA, exp);
    end
    axi.RREADY = 1;
    @(posedge ACLK); #1;
    axi.RREADY = 0;
    chk({tag, "_rvalid_clear"}, axi.RVALID, 0);
  endtask

  initial begin
    logic [3:0]  wa, ra;
    logic [31:0] wd, old;
    logic        bv;
    int          hi_cnt, t;

    axi.AWADDR = 0; axi.AWPROT = 0; axi.AWVALID = 0;
    axi.WDATA = 0; axi.WSTRB = 0; axi.WVALID = 0; axi.BREADY = 0;
    axi.ARADDR = 0; axi.ARPROT = 0; axi.ARVALID = 0; axi.RREADY = 0;
    for (int i = 0; i < 4; i++) mregs[i] = '0;

    ARESETN = 0;
    #100;
    chk("rst_awready", axi.AWREADY, 0);
    chk("rst_wready", axi.WREADY, 0);
    chk("rst_bvalid", axi.BVALID, 0);
    chk("rst_arready", axi.ARREADY, 0);
    chk("rst_rvalid", axi.RVALID, 0);
    chk("rst_rdata", axi.RDATA, 0);
    chk("rst_dout", dout, 0);
    ARESETN = 1;
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) axi_read_chk("rst_rd", 4'(i * 4), 32'h0);

    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read_chk("basic_rd", 4'(i * 4), 32'(i + 1));
    chk("basic_dout", dout, 16'h0000);

    axi_write(OFS_OE, 32'h0000_FFFF, 4'hF, 0, 0, 0);
    axi_write(OFS_DOUT, 32'h0, 4'hF, 0, 0, 0);
    axi_write(OFS_DOUT, 32'h1234_5678, 4'b0010, 2, 1, 0);
    axi_read_chk("strb_rd", OFS_DOUT, 32'h0000_5600);
    chk("strb_dout", dout, 16'h5600);

    axi_write(OFS_DOUT, 32'hFFFF_FFFF, 4'h0, 0, 0, 1);
    axi_read_chk("strb0_rd", OFS_DOUT, 32'h0000_5600);

    axi_write(OFS_DOUT, 32'h0000_00A5, 4'hF, 1, 3, 4);
    axi_read_chk("awfirst_rd", 4'h3, 32'h0000_00A5);
    chk("awfirst_dout", dout, 16'h00A5);

    // Read and write to PULSE_LEN start together: both land on the same edge.
    old = mregs[2];
    fork
      axi_write(OFS_PULSE_LEN, 32'hCAFE_0001, 4'hF, 0, 0, 0);
      axi_read_chk("same_cycle_rd", OFS_PULSE_LEN, old);
    join
    axi_read_chk("same_cycle_after", OFS_PULSE_LEN, 32'hCAFE_0001);

    for (int n = 0; n < 40; n++) begin
      wa = 4'($urandom_range(0, 15));
      wd = $urandom;
`ifdef DOUT_PULSE_EN
      if (wa[3:2] == 2'd3) wd[0] = 1'b0;
`endif
      axi_write(wa, wd, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 2));
      ra = 4'($urandom_range(0, 15));
      axi_read_chk("rand_rd", ra, mregs[ra[3:2]]);
      chk("rand_dout", dout, exp_dout());
    end

`ifdef DOUT_PULSE_EN
    hi_cnt = 0;
    axi_write(OFS_DOUT, 32'h0, 4'hF, 0, 0, 0);
    axi_write(OFS_PULSE_LEN, 32'd5, 4'hF, 0, 0, 0);
    axi_write(OFS_OE, 32'h0000_FFFF, 4'hF, 0, 0, 0);
    axi_write(OFS_CTRL, 32'h1, 4'hF, 0, 0, 0);
    fork
      axi_write(OFS_DOUT, 32'h0000_00FF, 4'hF, 0, 0, 0);
      for (int i = 0; i < 30; i++) begin
        @(posedge ACLK); #1;
        if (dout == 16'h00FF) hi_cnt++;
      end
    join
    chk("pulse_high_cycles", hi_cnt, 5);
    chk("pulse_end_dout", dout, 16'h0000);
    axi_read_chk("pulse_dout_rd", OFS_DOUT, 32'h0000_00FF);
    axi_write(OFS_CTRL, 32'h0, 4'hF, 0, 0, 0);
`else
    axi_write(OFS_PULSE_LEN, 32'd2, 4'hF, 0, 0, 0);
    axi_write(OFS_CTRL, 32'h1, 4'hF, 0, 0, 0);
    axi_write(OFS_OE, 32'h0000_FFFF, 4'hF, 0, 0, 0);
    axi_write(OFS_DOUT, 32'h0000_00FF, 4'hF, 0, 0, 0);
    repeat (10) @(posedge ACLK);
    #1;
    chk("nopulse_dout", dout, 16'h00FF);
    axi_write(OFS_CTRL, 32'h0, 4'hF, 0, 0, 0);
`endif

    axi_write(OFS_OE, 32'h0000_FFFF, 4'hF, 0, 0, 0);
    axi_write(OFS_DOUT, 32'h0000_1234, 4'hF, 0, 0, 0);
    chk("pre_rst_dout", dout, 16'h1234);

    axi.AWADDR  = OFS_OE;
    axi.AWVALID = 1;
    t = 0;
    while (!axi.AWREADY && t < 10) begin @(posedge ACLK); #1; t++; end
    chk("midrst_awready", axi.AWREADY, 1);
    @(posedge ACLK); #1;
    axi.AWVALID = 0;
    ARESETN = 0;
    #1;
    chk("midrst_dout_async", dout, 0);
    chk("midrst_bvalid", axi.BVALID, 0);
    chk("midrst_awready_clr", axi.AWREADY, 0);
    #30;
    ARESETN = 1;
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    bv = 0;
    repeat (10) begin @(posedge ACLK); #1; bv |= axi.BVALID; end
    chk("midrst_no_stale_bvalid", bv, 0);
    axi_read_chk("midrst_oe_rd", OFS_OE, 32'h0);
    axi_read_chk("midrst_dout_rd", OFS_DOUT, 32'h0);
    axi_write(OFS_OE, 32'hA5A5_0F0F, 4'hF, 0, 0, 1);
    axi_read_chk("midrst_next_rd", OFS_OE, 32'hA5A5_0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
